// File: rtl/exe_pipe_slice_pkg.sv
// Shared types and constants for the execute pipeline slice.
// Command codes, shift types, forwarding selects, flag indices and pipeline register layouts.
package exe_pipe_slice_pkg;

   localparam int W = 32;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [3:0] {
      CMD_MOV = 4'b0001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000,
      CMD_MVN = 4'b1001
   } exe_cmd_e;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_e;

   typedef enum logic [1:0] {
      SEL_REG = 2'b00,
      SEL_MEM = 2'b01,
      SEL_WB  = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic          wb_en;
      logic          mem_r_en;
      logic          mem_w_en;
      logic          b;
      logic          s;
      logic          imm;
      logic [3:0]    exe_cmd;
      logic [W-1:0]  pc;
      logic [W-1:0]  val_rn;
      logic [W-1:0]  val_rm;
      logic [11:0]   shift_operand;
      logic [23:0]   signed_imm_24;
      logic [3:0]    dest;
      logic [3:0]    src1;
      logic [3:0]    src2;
   } idex_t;

   typedef struct packed {
      logic          wb_en;
      logic          mem_r_en;
      logic          mem_w_en;
      logic [W-1:0]  alu_result;
      logic [W-1:0]  st_val;
      logic [3:0]    dest;
   } exmem_t;

   function automatic logic [W-1:0] ror32(input logic [W-1:0] x, input logic [4:0] n);
      logic [2*W-1:0] t;
      t = {x, x} >> n;
      return t[W-1:0];
   endfunction

endpackage

// File: rtl/exe_pipe_slice_if.sv
// Decode-side, forwarding and memory-side signal bundle for the execute slice.
interface exe_pipe_slice_if;
   import exe_pipe_slice_pkg::*;

   logic          freeze;
   logic          flush;
   logic          wb_en_in;
   logic          mem_r_en_in;
   logic          mem_w_en_in;
   logic          b_in;
   logic          s_in;
   logic          imm_in;
   logic [3:0]    exe_cmd_in;
   logic [W-1:0]  pc_in;
   logic [W-1:0]  val_rn_in;
   logic [W-1:0]  val_rm_in;
   logic [11:0]   shift_operand_in;
   logic [23:0]   signed_imm_24_in;
   logic [3:0]    dest_in;
   logic [3:0]    src1_in;
   logic [3:0]    src2_in;
   logic [1:0]    sel_src1;
   logic [1:0]    sel_src2;
   logic [W-1:0]  mem_alu_result;
   logic [W-1:0]  wb_val;
   logic [3:0]    sr;

   logic          b_exe;
   logic          s_exe;
   logic [3:0]    src1_exe;
   logic [3:0]    src2_exe;
   logic [3:0]    dest_exe;
   logic          wb_en_exe;
   logic          mem_r_en_exe;
   logic [W-1:0]  br_addr;
   logic [3:0]    status;
   logic          wb_en_mem;
   logic          mem_r_en_mem;
   logic          mem_w_en_mem;
   logic [W-1:0]  alu_result_mem;
   logic [W-1:0]  st_val_mem;
   logic [3:0]    dest_mem;

   modport slave (
      input  freeze, flush, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
             exe_cmd_in, pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
             dest_in, src1_in, src2_in, sel_src1, sel_src2, mem_alu_result, wb_val, sr,
      output b_exe, s_exe, src1_exe, src2_exe, dest_exe, wb_en_exe, mem_r_en_exe,
             br_addr, status, wb_en_mem, mem_r_en_mem, mem_w_en_mem,
             alu_result_mem, st_val_mem, dest_mem
   );

   modport master (
      output freeze, flush, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
             exe_cmd_in, pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
             dest_in, src1_in, src2_in, sel_src1, sel_src2, mem_alu_result, wb_val, sr,
      input  b_exe, s_exe, src1_exe, src2_exe, dest_exe, wb_en_exe, mem_r_en_exe,
             br_addr, status, wb_en_mem, mem_r_en_mem, mem_w_en_mem,
             alu_result_mem, st_val_mem, dest_mem
   );

endinterface

// File: rtl/exe_pipe_slice_alu.sv
// Execute ALU: command, op1, Val2 and carry-in to result and {N,Z,C,V} flags.
module exe_alu
   import exe_pipe_slice_pkg::*;
(
   input  logic [3:0]    cmd,
   input  logic [W-1:0]  op1,
   input  logic [W-1:0]  val2,
   input  logic          c_in,
   output logic [W-1:0]  result,
   output logic [3:0]    flags
);

   logic [W:0] sum;
   logic       arith;
   logic       sub;

   // Subtraction runs as op1 + ~val2 + carry so bit W is the no-borrow carry.
   always_comb begin
      sum   = '0;
      arith = 1'b0;
      sub   = 1'b0;
      case (cmd)
         CMD_MOV: sum = {1'b0, val2};
         CMD_MVN: sum = {1'b0, ~val2};
         CMD_ADD: begin
            sum   = {1'b0, op1} + {1'b0, val2};
            arith = 1'b1;
         end
         CMD_ADC: begin
            sum   = {1'b0, op1} + {1'b0, val2} + {{W{1'b0}}, c_in};
            arith = 1'b1;
         end
         CMD_SUB: begin
            sum   = {1'b0, op1} + {1'b0, ~val2} + {{W{1'b0}}, 1'b1};
            arith = 1'b1;
            sub   = 1'b1;
         end
         CMD_SBC: begin
            sum   = {1'b0, op1} + {1'b0, ~val2} + {{W{1'b0}}, c_in};
            arith = 1'b1;
            sub   = 1'b1;
         end
         CMD_AND: sum = {1'b0, op1 & val2};
         CMD_ORR: sum = {1'b0, op1 | val2};
         CMD_EOR: sum = {1'b0, op1 ^ val2};
         default: sum = '0;
      endcase
   end

   assign result = sum[W-1:0];

   always_comb begin
      flags         = '0;
      flags[FLAG_N] = result[W-1];
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_C] = arith & sum[W];
      if (arith) begin
         if (sub)
            flags[FLAG_V] = (op1[W-1] != val2[W-1]) && (result[W-1] != op1[W-1]);
         else
            flags[FLAG_V] = (op1[W-1] == val2[W-1]) && (result[W-1] != op1[W-1]);
      end
   end

endmodule

// File: rtl/exe_pipe_slice.sv
// Execute slice: ID/EX register, forwarding, Val2, ALU, branch adder, EX/MEM register.
// Optional macro FORWARDING_EN: honour sel_src1/sel_src2; otherwise register values are used.
module exe_pipe_slice
   import exe_pipe_slice_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   exe_pipe_slice_if.slave bus
);

   idex_t         id_d;
   idex_t         ex_q;
   exmem_t        mem_d;
   exmem_t        mem_q;
   logic [1:0]    sel1;
   logic [1:0]    sel2;
   logic [W-1:0]  op1;
   logic [W-1:0]  rm_f;
   logic [W-1:0]  val2;
   logic [W-1:0]  alu_result;
   logic [3:0]    alu_flags;
   logic [4:0]    sh_amt;
   logic          unused_flags;

   assign id_d = '{
      wb_en:         bus.wb_en_in,
      mem_r_en:      bus.mem_r_en_in,
      mem_w_en:      bus.mem_w_en_in,
      b:             bus.b_in,
      s:             bus.s_in,
      imm:           bus.imm_in,
      exe_cmd:       bus.exe_cmd_in,
      pc:            bus.pc_in,
      val_rn:        bus.val_rn_in,
      val_rm:        bus.val_rm_in,
      shift_operand: bus.shift_operand_in,
      signed_imm_24: bus.signed_imm_24_in,
      dest:          bus.dest_in,
      src1:          bus.src1_in,
      src2:          bus.src2_in
   };

   // Freeze outranks flush so a stalled branch does not lose the instruction in EX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ex_q <= '0;
      else if (!bus.freeze) begin
         if (bus.flush)
            ex_q <= '0;
         else
            ex_q <= id_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mem_q <= '0;
      else if (!bus.freeze)
         mem_q <= mem_d;
   end

`ifdef FORWARDING_EN
   assign sel1 = bus.sel_src1;
   assign sel2 = bus.sel_src2;
`else
   logic unused_fwd;
   assign unused_fwd = ^{bus.sel_src1, bus.sel_src2, bus.mem_alu_result, bus.wb_val};
   assign sel1 = SEL_REG;
   assign sel2 = SEL_REG;
`endif

   function automatic logic [W-1:0] fwd(input logic [1:0] sel, input logic [W-1:0] reg_val,
                                        input logic [W-1:0] mem_val, input logic [W-1:0] wb);
      case (sel)
         SEL_MEM: return mem_val;
         SEL_WB:  return wb;
         default: return reg_val;
      endcase
   endfunction

   assign op1  = fwd(sel1, ex_q.val_rn, bus.mem_alu_result, bus.wb_val);
   assign rm_f = fwd(sel2, ex_q.val_rm, bus.mem_alu_result, bus.wb_val);

   assign sh_amt = ex_q.shift_operand[11:7];

   always_comb begin
      val2 = '0;
      if (ex_q.imm)
         val2 = ror32({24'b0, ex_q.shift_operand[7:0]}, {ex_q.shift_operand[11:8], 1'b0});
      else if (ex_q.mem_r_en || ex_q.mem_w_en)
         val2 = {20'b0, ex_q.shift_operand};
      else begin
         case (ex_q.shift_operand[6:5])
            SH_LSL:  val2 = rm_f << sh_amt;
            SH_LSR:  val2 = rm_f >> sh_amt;
            SH_ASR:  val2 = W'($signed(rm_f) >>> sh_amt);
            default: val2 = ror32(rm_f, sh_amt);
         endcase
      end
   end

   exe_alu u_alu (
      .cmd    (ex_q.exe_cmd),
      .op1    (op1),
      .val2   (val2),
      .c_in   (bus.sr[FLAG_C]),
      .result (alu_result),
      .flags  (alu_flags)
   );

   assign unused_flags = ^{bus.sr[FLAG_N], bus.sr[FLAG_Z], bus.sr[FLAG_V]};

   assign mem_d = '{
      wb_en:      ex_q.wb_en,
      mem_r_en:   ex_q.mem_r_en,
      mem_w_en:   ex_q.mem_w_en,
      alu_result: alu_result,
      st_val:     rm_f,
      dest:       ex_q.dest
   };

   assign bus.br_addr      = ex_q.pc + {{6{ex_q.signed_imm_24[23]}}, ex_q.signed_imm_24, 2'b00};
   assign bus.status       = alu_flags;
   assign bus.b_exe        = ex_q.b;
   assign bus.s_exe        = ex_q.s;
   assign bus.src1_exe     = ex_q.src1;
   assign bus.src2_exe     = ex_q.src2;
   assign bus.dest_exe     = ex_q.dest;
   assign bus.wb_en_exe    = ex_q.wb_en;
   assign bus.mem_r_en_exe = ex_q.mem_r_en;

   assign bus.wb_en_mem      = mem_q.wb_en;
   assign bus.mem_r_en_mem   = mem_q.mem_r_en;
   assign bus.mem_w_en_mem   = mem_q.mem_w_en;
   assign bus.alu_result_mem = mem_q.alu_result;
   assign bus.st_val_mem     = mem_q.st_val;
   assign bus.dest_mem       = mem_q.dest;

endmodule

// File: tb/tb_exe_pipe_slice.sv
// Randomized bench for exe_pipe_slice against an arithmetic reference model, plus directed literal checks.
module tb_exe_pipe_slice;

   logic clk;
   logic rst;
   exe_pipe_slice_if bus();

   exe_pipe_slice dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_on   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        wb_en, mem_r_en, mem_w_en, b, s, imm;
      logic [3:0]  cmd;
      logic [31:0] pc, rn, rm;
      logic [11:0] so;
      logic [23:0] simm;
      logic [3:0]  dest, src1, src2;
   } m_idex_t;

   typedef struct {
      logic        wb_en, mem_r_en, mem_w_en;
      logic [31:0] alu, st;
      logic [3:0]  dest;
   } m_exmem_t;

   m_idex_t     mi;
   m_exmem_t    mm;
   logic [31:0] m_res, m_rmf, m_br;
   logic [3:0]  m_fl;

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                        input logic [31:0] mv, input logic [31:0] wv);
`ifdef FORWARDING_EN
      if (sel == 2'd1) return mv;
      if (sel == 2'd2) return wv;
`endif
      return r;
   endfunction

   function automatic logic [31:0] rot_right(input logic [31:0] x, input int n);
      logic [31:0] y = x;
      for (int k = 0; k < n; k++) y = {y[0], y[31:1]};
      return y;
   endfunction

   function automatic logic [31:0] m_val2(input m_idex_t s, input logic [31:0] rmf);
      int n;
      logic [31:0] y;
      if (s.imm) return rot_right({24'b0, s.so[7:0]}, 2 * int'(s.so[11:8]));
      if (s.mem_r_en || s.mem_w_en) return {20'b0, s.so};
      n = int'(s.so[11:7]);
      y = rmf;
      case (s.so[6:5])
         2'd0: for (int k = 0; k < n; k++) y = {y[30:0], 1'b0};
         2'd1: for (int k = 0; k < n; k++) y = {1'b0, y[31:1]};
         2'd2: for (int k = 0; k < n; k++) y = {y[31], y[31:1]};
         default: y = rot_right(y, n);
      endcase
      return y;
   endfunction

   function automatic void m_exec(input m_idex_t s, input logic [1:0] s1, input logic [1:0] s2,
                                  input logic [31:0] mv, input logic [31:0] wv, input logic [3:0] srv,
                                  output logic [31:0] res, output logic [3:0] fl,
                                  output logic [31:0] rmf, output logic [31:0] br);
      logic [31:0] a, v2;
      longint      t, ua, ub, cin;
      logic        c, v;
      int          off;
      a   = pick(s1, s.rn, mv, wv);
      rmf = pick(s2, s.rm, mv, wv);
      v2  = m_val2(s, rmf);
      ua  = longint'({32'b0, a});
      ub  = longint'({32'b0, v2});
      cin = srv[1] ? 64'sd1 : 64'sd0;
      c = 0; v = 0; res = 0;
      case (s.cmd)
         4'd1: res = v2;
         4'd9: res = ~v2;
         4'd2, 4'd3: begin
            t   = ua + ub + ((s.cmd == 4'd3) ? cin : 64'sd0);
            res = t[31:0];
            c   = (t >= 64'sd4294967296);
            v   = (a[31] == v2[31]) && (res[31] != a[31]);
         end
         4'd4, 4'd5: begin
            t   = ua - ub - ((s.cmd == 4'd5) ? (64'sd1 - cin) : 64'sd0);
            res = t[31:0];
            c   = (t >= 0);
            v   = (a[31] != v2[31]) && (res[31] != a[31]);
         end
         4'd6: res = a & v2;
         4'd7: res = a | v2;
         4'd8: res = a ^ v2;
         default: res = 0;
      endcase
      fl  = {res[31], (res == 0), c, v};
      off = s.simm[23] ? int'(s.simm) - (1 << 24) : int'(s.simm);
      br  = s.pc + 32'(off * 4);
   endfunction

   always_comb m_exec(mi, bus.sel_src1, bus.sel_src2, bus.mem_alu_result, bus.wb_val, bus.sr,
                      m_res, m_fl, m_rmf, m_br);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mi <= '{default: '0};
         mm <= '{default: '0};
      end else if (!bus.freeze) begin
         mm <= '{wb_en: mi.wb_en, mem_r_en: mi.mem_r_en, mem_w_en: mi.mem_w_en,
                 alu: m_res, st: m_rmf, dest: mi.dest};
         if (bus.flush)
            mi <= '{default: '0};
         else
            mi <= '{wb_en: bus.wb_en_in, mem_r_en: bus.mem_r_en_in, mem_w_en: bus.mem_w_en_in,
                    b: bus.b_in, s: bus.s_in, imm: bus.imm_in, cmd: bus.exe_cmd_in,
                    pc: bus.pc_in, rn: bus.val_rn_in, rm: bus.val_rm_in,
                    so: bus.shift_operand_in, simm: bus.signed_imm_24_in,
                    dest: bus.dest_in, src1: bus.src1_in, src2: bus.src2_in};
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("exe_ctrl",
             {bus.b_exe, bus.s_exe, bus.src1_exe, bus.src2_exe, bus.dest_exe, bus.wb_en_exe, bus.mem_r_en_exe},
             {mi.b, mi.s, mi.src1, mi.src2, mi.dest, mi.wb_en, mi.mem_r_en});
         chk("br_addr", bus.br_addr, m_br);
         chk("status", bus.status, m_fl);
         chk("mem_ctrl", {bus.wb_en_mem, bus.mem_r_en_mem, bus.mem_w_en_mem, bus.dest_mem},
             {mm.wb_en, mm.mem_r_en, mm.mem_w_en, mm.dest});
         chk("alu_result_mem", bus.alu_result_mem, mm.alu);
         chk("st_val_mem", bus.st_val_mem, mm.st);
      end
   end

   task automatic idle();
      bus.freeze = 0; bus.flush = 0;
      bus.wb_en_in = 0; bus.mem_r_en_in = 0; bus.mem_w_en_in = 0;
      bus.b_in = 0; bus.s_in = 0; bus.imm_in = 0; bus.exe_cmd_in = 0;
      bus.pc_in = 0; bus.val_rn_in = 0; bus.val_rm_in = 0;
      bus.shift_operand_in = 0; bus.signed_imm_24_in = 0;
      bus.dest_in = 0; bus.src1_in = 0; bus.src2_in = 0;
      bus.sel_src1 = 0; bus.sel_src2 = 0;
      bus.mem_alu_result = 0; bus.wb_val = 0; bus.sr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic randomize_inputs();
      bus.freeze = ($urandom_range(0, 9) == 0);
      bus.flush  = ($urandom_range(0, 7) == 0);
      bus.wb_en_in = 1'($urandom); bus.b_in = 1'($urandom); bus.s_in = 1'($urandom);
      bus.mem_r_en_in = ($urandom_range(0, 4) == 0);
      bus.mem_w_en_in = ($urandom_range(0, 4) == 0);
      bus.imm_in = 1'($urandom);
      bus.exe_cmd_in = 4'($urandom_range(0, 15));
      bus.pc_in = $urandom; bus.val_rn_in = $urandom; bus.val_rm_in = $urandom;
      if ($urandom_range(0, 3) == 0) bus.val_rm_in = bus.val_rn_in;
      if ($urandom_range(0, 5) == 0) bus.val_rn_in = 32'h7FFFFFFF ^ 32'($urandom_range(0, 3));
      bus.shift_operand_in = 12'($urandom); bus.signed_imm_24_in = 24'($urandom);
      bus.dest_in = 4'($urandom); bus.src1_in = 4'($urandom); bus.src2_in = 4'($urandom);
      bus.sel_src1 = 2'($urandom); bus.sel_src2 = 2'($urandom);
      bus.mem_alu_result = $urandom; bus.wb_val = $urandom; bus.sr = 4'($urandom);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] fwd_exp;
      rst = 0;
      idle();
      #1 rst = 1;
      #20;
      chk("rst_alu_result_mem", bus.alu_result_mem, 32'h0);
      chk("rst_dest_exe", bus.dest_exe, 4'h0);
      chk("rst_br_addr", bus.br_addr, 32'h0);
      chk("rst_status", bus.status, 4'b0100);
      sample();
      rst = 0;
      cmp_on = 1;

      // ADD overflow into sign bit
      idle(); bus.wb_en_in = 1; bus.exe_cmd_in = 4'b0010; bus.imm_in = 1;
      bus.shift_operand_in = 12'h001; bus.val_rn_in = 32'h7FFFFFFF; bus.dest_in = 4'd3;
      step(); idle();
      sample(); chk("add_status", bus.status, 4'b1001);
      step(); sample();
      chk("add_result", bus.alu_result_mem, 32'h80000000);
      chk("add_dest_mem", {bus.wb_en_mem, bus.dest_mem}, {1'b1, 4'd3});

      // SUB to zero
      idle(); bus.exe_cmd_in = 4'b0100; bus.imm_in = 1;
      bus.shift_operand_in = 12'h005; bus.val_rn_in = 32'd5;
      step(); idle();
      sample(); chk("sub_status", bus.status, 4'b0110);
      step(); sample(); chk("sub_result", bus.alu_result_mem, 32'h0);

      // rotated immediate
      idle(); bus.exe_cmd_in = 4'b0001; bus.imm_in = 1; bus.shift_operand_in = 12'h4FF;
      step(); idle(); step(); sample();
      chk("imm_rot_val2", bus.alu_result_mem, 32'hFF000000);

      // register ASR by 4
      idle(); bus.exe_cmd_in = 4'b0001; bus.shift_operand_in = 12'h240; bus.val_rm_in = 32'h80000000;
      step(); idle(); step(); sample();
      chk("asr_val2", bus.alu_result_mem, 32'hF8000000);
      chk("asr_st_val", bus.st_val_mem, 32'h80000000);

      // forwarding from MEM stage
      idle(); bus.exe_cmd_in = 4'b0010; bus.imm_in = 1; bus.shift_operand_in = 12'h001; bus.val_rn_in = 32'd3;
      step(); idle(); bus.sel_src1 = 2'b01; bus.mem_alu_result = 32'd10;
      step(); idle(); sample();
`ifdef FORWARDING_EN
      fwd_exp = 32'd11;
`else
      fwd_exp = 32'd4;
`endif
      chk("fwd_add", bus.alu_result_mem, fwd_exp);

      // branch target
      idle(); bus.pc_in = 32'h100; bus.signed_imm_24_in = 24'hFFFFFF;
      step(); idle(); sample();
      chk("br_addr_neg", bus.br_addr, 32'hFC);

      // flush clears ID/EX
      idle(); bus.b_in = 1; bus.s_in = 1; bus.src1_in = 4'd5; bus.src2_in = 4'd6; bus.dest_in = 4'd7;
      bus.wb_en_in = 1; bus.mem_r_en_in = 1; bus.pc_in = 32'h40;
      step(); bus.flush = 1;
      sample(); chk("pre_flush_dest", bus.dest_exe, 4'd7);
      step(); idle(); sample();
      chk("flush_exe", {bus.b_exe, bus.s_exe, bus.src1_exe, bus.src2_exe, bus.dest_exe,
                        bus.wb_en_exe, bus.mem_r_en_exe}, 17'h0);
      chk("flush_br_addr", bus.br_addr, 32'h0);
      chk("flush_mem_dest", bus.dest_mem, 4'd7);

      // freeze holds both registers, even against a flush
      idle(); bus.dest_in = 4'd9; bus.exe_cmd_in = 4'b0001; bus.imm_in = 1; bus.shift_operand_in = 12'h0AB;
      step(); idle(); bus.dest_in = 4'd4;
      step(); bus.freeze = 1; bus.flush = 1; bus.dest_in = 4'd12;
      for (int i = 0; i < 3; i++) begin
         step(); sample();
         chk("freeze_dest_exe", bus.dest_exe, 4'd4);
         chk("freeze_mem", {bus.dest_mem, bus.alu_result_mem}, {4'd9, 32'hAB});
      end
      idle(); step(); sample();
      chk("unfreeze", {bus.dest_exe, bus.dest_mem}, {4'd0, 4'd4});

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step();
         randomize_inputs();
      end

      // asynchronous reset between edges
      idle(); bus.dest_in = 4'd5; bus.wb_en_in = 1;
      step(); step();
      #3 rst = 1;
      #1;
      chk("async_rst_exe", {bus.dest_exe, bus.wb_en_exe}, 5'h0);
      chk("async_rst_mem", {bus.dest_mem, bus.wb_en_mem, bus.alu_result_mem}, 37'h0);
      sample(); rst = 0;
      step(); sample();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exe_pipe_slice.md
Name: exe_pipe_slice

Overview:
- Execute slice of the 5-stage ARM pipeline: ID/EX pipeline register, execute logic (forwarding muxes, Val2 generator, ALU, branch-target adder), and EX/MEM pipeline register.
- Sits between the decode stage and the memory stage.
- Status flags are produced for the external status register; the current flags (SR) come back in as an input.

Parameters:
- W, 32, datapath width (fixed at 32).

Ports:
- clk in 1: rising-edge clock.
- rst in 1: reset, asynchronous, active-high.
- freeze in 1: hold both pipeline registers (memory not ready).
- flush in 1: clear the ID/EX register (branch taken).
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in in 1 each: decoded control bits.
- exe_cmd_in in 4: ALU command.
- pc_in, val_rn_in, val_rm_in in 32 each: PC and register operands.
- shift_operand_in in 12; signed_imm_24_in in 24; dest_in, src1_in, src2_in in 4 each.
- sel_src1, sel_src2 in 2 each: forwarding selects.
- mem_alu_result, wb_val in 32 each: forwarded values.
- sr in 4: current flags {N,Z,C,V}.
- b_exe, s_exe out 1 each: registered branch and flag-update bits.
- src1_exe, src2_exe, dest_exe out 4 each: registered register indices.
- wb_en_exe, mem_r_en_exe out 1 each: registered, for the hazard unit.
- br_addr out 32: branch target (combinational).
- status out 4: new flags (combinational).
- wb_en_mem, mem_r_en_mem, mem_w_en_mem out 1 each.
- alu_result_mem, st_val_mem out 32 each.
- dest_mem out 4.

Behaviour:
- Both registers:
  - rst clears every stored field to 0 asynchronously.
  - Priority per clock edge: rst > freeze (hold) > flush (ID/EX only; clear to 0) > load.
- Forwarded operands:
  - sel = 00 selects the register value, 01 selects mem_alu_result, 10 selects wb_val, 11 is treated as 00.
  - op1 = forwarded val_rn; rm_f = forwarded val_rm.
- Val2 selection:
  - If imm: the 8-bit shift_operand[7:0], zero-extended, rotated right by 2*shift_operand[11:8].
  - Else if mem_r_en or mem_w_en: shift_operand[11:0], zero-extended.
  - Else: rm_f shifted by shift_operand[11:7] using type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- ALU commands (C_in = sr[1]):
  - 0001 MOV: Val2.
  - 1001 MVN: ~Val2.
  - 0010 ADD: op1+Val2.
  - 0011 ADC: op1+Val2+C_in.
  - 0100 SUB: op1-Val2.
  - 0101 SBC: op1-Val2-~C_in.
  - 0110 AND; 0111 ORR; 1000 EOR.
  - Any other code: result 0.
- Flags:
  - N = result[31]; Z = (result == 0).
  - Arithmetic ops: C = 33-bit carry-out. V = signed overflow (add: operands same sign and result differs; sub: operands differ in sign and result sign differs from op1).
  - Logic and move ops: C = 0, V = 0.
- Branch: br_addr = pc_exe + (sign_extend(signed_imm_24) << 2), 32-bit wrap.
- EX/MEM register loads {wb_en, mem_r_en, mem_w_en, ALU result, rm_f as st_val, dest}.
- Latency: ID/EX → EX/MEM is one cycle.
- flush and freeze in the same cycle: freeze wins, nothing changes.

Optional Feature:
- FORWARDING_EN defined: sel_src1/sel_src2 are honoured as above.
- FORWARDING_EN undefined: sel inputs are ignored and treated as 00; register values are always used.

Decomposition:
- Shared package: EXE_CMD codes, shift-type codes, forwarding-select codes (SEL_REG, SEL_MEM, SEL_WB), flag bit indices (N=3, Z=2, C=1, V=0).
- One sub-module: exe_alu (command, op1, Val2, C_in → result, flags).

Test Plan:
- ADD, op1 = 0x7FFFFFFF, Val2 = 1 → alu_result_mem = 0x80000000 next cycle; status {N,Z,C,V} = 1001.
- SUB, op1 = 5, Val2 = 5 → result 0; status = 0110.
- imm = 1, shift_operand = 0x4FF → Val2 = 0xFF000000.
- Reg mode, ASR by 4 (shift_operand = 0x240), rm = 0x80000000 → Val2 = 0xF8000000.
- sel_src1 = 01, mem_alu_result = 10, val_rn = 3, ADD with imm 1 → 11.
- pc = 0x100, signed_imm_24 = 0xFFFFFF → br_addr = 0xFC.
- flush = 1 → ID/EX fields 0 next cycle.
- freeze = 1 for 3 cycles → both registers hold.
- rst mid-cycle → all outputs 0 immediately.
